// File: rtl/ten_gig_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of one 10G MAC tx_axis port.
// Grants are only issued while the link is up. A grant is held until the
// frame ends. Frames longer than P_MAX_BEATS are cut short and flagged bad
// on the master side, and the rest of the source frame is swallowed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no grant; pick the next valid source when the link is up
// ST_XFER  | granted source muxed straight through to the MAC
// ST_DRAIN | frame was truncated; discard source beats up to its tlast
module ten_gig_tx_arbiter #(
   parameter int          P_SRC_NUM   = 2,
   parameter logic [15:0] P_MAX_BEATS = 16'd1200
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_link_up,
   input  logic [P_SRC_NUM-1:0]      s_axis_tvalid,
   input  logic [64*P_SRC_NUM-1:0]   s_axis_tdata,
   input  logic [8*P_SRC_NUM-1:0]    s_axis_tkeep,
   input  logic [P_SRC_NUM-1:0]      s_axis_tlast,
   input  logic [P_SRC_NUM-1:0]      s_axis_tuser,
   output logic [P_SRC_NUM-1:0]      s_axis_tready,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tvalid,
   output logic [63:0]               m_axis_tdata,
   output logic [7:0]                m_axis_tkeep,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tuser,
   output logic [P_SRC_NUM-1:0]      o_grant,
   output logic                      o_busy,
   output logic [15:0]               o_trunc_cnt
);

   localparam int PTR_W = (P_SRC_NUM > 1) ? $clog2(P_SRC_NUM) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_XFER,
      ST_DRAIN
   } state_t;

   state_t               state_q, state_d;
   logic [P_SRC_NUM-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]     gidx_q, gidx_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [15:0]          beat_cnt_q, beat_cnt_d;
   logic [15:0]          trunc_cnt_q, trunc_cnt_d;

   logic                 sel_found;
   logic [PTR_W-1:0]     sel_idx;
   logic [P_SRC_NUM-1:0] sel_onehot;
   logic [2*P_SRC_NUM-1:0] vld_rot;
   logic [PTR_W:0]       sel_sum;

   logic                 g_valid;
   logic [63:0]          g_data;
   logic [7:0]           g_keep;
   logic                 g_last;
   logic                 g_user;
   logic                 at_max_beat;
   logic                 trunc_beat;
   logic [PTR_W-1:0]     next_ptr;

   // Rotate valids so bit 0 is rr_ptr, then take the first set bit; the
   // winning index is rr_ptr plus that offset, wrapped at P_SRC_NUM.
   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      sel_sum    = '0;
      sel_onehot = '0;
      vld_rot    = {s_axis_tvalid, s_axis_tvalid} >> rr_ptr_q;
      for (int i = 0; i < P_SRC_NUM; i++) begin
         if (!sel_found && vld_rot[i]) begin
            sel_found = 1'b1;
            sel_sum   = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (sel_sum >= (PTR_W+1)'(P_SRC_NUM)) begin
               sel_sum = sel_sum - (PTR_W+1)'(P_SRC_NUM);
            end
            sel_idx = sel_sum[PTR_W-1:0];
         end
      end
      for (int i = 0; i < P_SRC_NUM; i++) begin
         if (sel_idx == PTR_W'(i)) begin
            sel_onehot[i] = 1'b1;
         end
      end
   end

   // Select the granted source's stream for the master port and handshake.
   always_comb begin
      g_valid = 1'b0;
      g_data  = '0;
      g_keep  = '0;
      g_last  = 1'b0;
      g_user  = 1'b0;
      for (int i = 0; i < P_SRC_NUM; i++) begin
         if (gidx_q == PTR_W'(i)) begin
            g_valid = s_axis_tvalid[i];
            g_data  = s_axis_tdata[64*i +: 64];
            g_keep  = s_axis_tkeep[8*i +: 8];
            g_last  = s_axis_tlast[i];
            g_user  = s_axis_tuser[i];
         end
      end
   end

   // A real tlast on the limit beat is a normal end, so only force when absent.
   assign at_max_beat = (beat_cnt_q == (P_MAX_BEATS - 16'd1));
   assign trunc_beat  = at_max_beat && !g_last;
   assign next_ptr    = (gidx_q == PTR_W'(P_SRC_NUM-1)) ? '0 : gidx_q + PTR_W'(1);

   // Next-state: arbitration in IDLE, beat counting and truncation in XFER.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      gidx_d      = gidx_q;
      rr_ptr_d    = rr_ptr_q;
      beat_cnt_d  = beat_cnt_q;
      trunc_cnt_d = trunc_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (i_link_up && sel_found) begin
               grant_d    = sel_onehot;
               gidx_d     = sel_idx;
               beat_cnt_d = '0;
               state_d    = ST_XFER;
            end
         end
         ST_XFER: begin
            if (g_valid && m_axis_tready) begin
               beat_cnt_d = beat_cnt_q + 16'd1;
               if (g_last) begin
                  grant_d  = '0;
                  rr_ptr_d = next_ptr;
                  state_d  = ST_IDLE;
               end else if (at_max_beat) begin
                  if (trunc_cnt_q != 16'hFFFF) begin
                     trunc_cnt_d = trunc_cnt_q + 16'd1;
                  end
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (g_valid && g_last) begin
               grant_d  = '0;
               rr_ptr_d = next_ptr;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Master outputs and per-source ready; everything quiet outside XFER/DRAIN.
   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      s_axis_tready = '0;
      case (state_q)
         ST_XFER: begin
            m_axis_tvalid = g_valid;
            m_axis_tdata  = g_data;
            m_axis_tkeep  = g_keep;
            m_axis_tlast  = g_last | trunc_beat;
            m_axis_tuser  = g_user | trunc_beat;
            s_axis_tready = grant_q & {P_SRC_NUM{m_axis_tready}};
         end
         ST_DRAIN: begin
            s_axis_tready = grant_q;
         end
         default: begin
         end
      endcase
   end

   // State registers; reset drops any frame in flight and restarts at source 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         gidx_q      <= '0;
         rr_ptr_q    <= '0;
         beat_cnt_q  <= '0;
         trunc_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         gidx_q      <= gidx_d;
         rr_ptr_q    <= rr_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         trunc_cnt_q <= trunc_cnt_d;
      end
   end

   assign o_grant     = grant_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_trunc_cnt = trunc_cnt_q;

endmodule

// File: doc/ten_gig_tx_arbiter.md
# ten_gig_tx_arbiter

Packet-granular round-robin arbiter sharing one 10G Ethernet MAC transmit AXI-Stream port (64-bit, per channel of the 10G channel wrapper) between P_SRC_NUM upstream packet sources. It sits in the MAC TX clock domain, directly in front of the channel's tx_axis port. Grants are issued only while the link is up and are held for a whole frame. Frames exceeding P_MAX_BEATS are truncated and marked bad. Their remainder is discarded.

## Interface
Parameters:
- P_SRC_NUM, 2, number of requesting sources (2..8)
- P_MAX_BEATS, 16'd1200, maximum beats per frame (9600 B / 8)

Ports:
- i_clk  in  1  MAC TX user clock (tx_clk_out)
- i_rst_n  in  1  reset, asynchronous, active-low
- i_link_up  in  1  MAC stat_rx_status, synchronous to i_clk
- s_axis_tvalid  in  P_SRC_NUM  per-source valid
- s_axis_tdata  in  64*P_SRC_NUM  source k at [64k+63:64k]
- s_axis_tkeep  in  8*P_SRC_NUM  source k at [8k+7:8k]
- s_axis_tlast  in  P_SRC_NUM  per-source end of frame
- s_axis_tuser  in  P_SRC_NUM  per-source bad-frame flag
- s_axis_tready  out  P_SRC_NUM  per-source ready
- m_axis_tready  in  1  MAC tx_axis_tready
- m_axis_tvalid  out  1  to MAC
- m_axis_tdata  out  64  to MAC
- m_axis_tkeep  out  8  to MAC
- m_axis_tlast  out  1  to MAC
- m_axis_tuser  out  1  to MAC
- o_grant  out  P_SRC_NUM  one-hot current grant, registered
- o_busy  out  1  high in XFER or DRAIN
- o_trunc_cnt  out  16  count of truncated frames, saturating at 16'hFFFF

## Operation
- States: IDLE, XFER, DRAIN. Reset state IDLE.
- IDLE: if i_link_up=1 and any s_axis_tvalid=1, select the first valid source at or after rr_ptr, searching upward modulo P_SRC_NUM. Register its one-hot code into o_grant. Clear beat_cnt. Go to XFER. Otherwise stay. In IDLE, all s_axis_tready=0 and m_axis_tvalid=0.
- XFER: granted source g is combinationally muxed to the master port. m_axis_tvalid=s_axis_tvalid[g], data/keep/last/user follow source g, s_axis_tready[g]=m_axis_tready. All other sources see tready=0.
  - A beat is accepted when m_axis_tvalid & m_axis_tready. Each accepted beat increments beat_cnt (16-bit).
  - Accepted beat with s_axis_tlast[g]=1: go to IDLE, clear o_grant, rr_ptr = (g+1) mod P_SRC_NUM.
  - Accepted beat with tlast=0 and beat_cnt==P_MAX_BEATS-1 (the P_MAX_BEATS-th beat): on that beat the outputs are forced to m_axis_tlast=1 and m_axis_tuser=1. o_trunc_cnt increments. Go to DRAIN.
  - If the P_MAX_BEATS-th beat carries a real tlast, it is a normal end. No truncation occurs.
- DRAIN: m_axis_tvalid=0. s_axis_tready[g]=1. Source beats are discarded until a beat with tlast=1 is accepted. Then go to IDLE, clear o_grant, and advance rr_ptr as above.
- i_link_up is sampled only in IDLE. A link drop mid-frame does not abort the frame; the MAC handles it.
- rr_ptr width is clog2(P_SRC_NUM). It resets to 0.

## Timing
- Reset values: o_grant=0, o_busy=0, o_trunc_cnt=0, m_axis_tvalid=0, s_axis_tready=0, m_axis_tlast=0, m_axis_tuser=0. m_axis_tdata and m_axis_tkeep are 0 while not in XFER.
- Arbitration latency: the first source tvalid is seen in IDLE at cycle t. o_grant and the first possible m_axis_tvalid follow at t+1.
- Data path latency: 0 cycles in XFER (combinational mux). tready is returned combinationally from the MAC to the granted source.
- Frame gap: exactly 1 IDLE cycle between the last accepted beat of one frame and the first beat of the next.
- Source valid must stay asserted until accepted (AXIS rule). The arbiter never deasserts a grant mid-frame.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). The frame is lost. After reset, arbitration restarts from source 0.

## Test plan
- Single source: source 0 sends a 10-beat frame, tready=1, link up. -> o_grant=01 at t+1, 10 beats pass unchanged, tlast on beat 10, IDLE for one cycle, o_trunc_cnt=0.
- Round-robin: both sources hold continuous 4-beat frames. -> grants alternate 01,10,01,10. Each master frame is 4 beats with a 1-cycle gap. No beat interleaving between sources.
- Backpressure: m_axis_tready toggles 1,0,1,0 during a 6-beat frame. -> the granted source's tready mirrors it. Exactly 6 beats are accepted. Held data is stable while stalled.
- Link gating: i_link_up=0 with source 1 valid. -> no grant, all tready=0. Raise the link. -> o_grant=10 on the next cycle.
- Truncation: with P_MAX_BEATS=8, source 0 sends a 12-beat frame. -> the master sees 8 beats, beat 8 has tlast=1 and tuser=1. Beats 9-12 are consumed with m_axis_tvalid=0. o_trunc_cnt=1. The next grant goes to source 1 if it is valid.
- Reset mid-frame: assert i_rst_n=0 on beat 3 of 5. -> all outputs go to 0 immediately. After release, source 1 and source 0 both valid. -> source 0 is granted first (rr_ptr=0).
